cmos_shift_reg: RTL and testbench

- Parametrised WIDTH-bit shift/load register built at switch level.
- Storage is static master-slave flip-flops made from pmos/nmos inverters and cmos transmission gates; there is no behavioural always-block storage.
- Control/next-state muxing uses transmission gates. A small fill counter reports how many serial bits have entered since reset or load.
- Sits beside the single-inverter lab cell as the next-generation teaching block: the first sequential transistor-level design.

---
 rtl/cmos_shift_reg_if.sv | 27 ++
 rtl/cmos_shift_reg.sv | 175 +++++++++++++++++
 tb/tb_cmos_shift_reg.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/cmos_shift_reg_if.sv
// Control, data and status bundle for cmos_shift_reg.
// The bench drives it through master; the register connects through slave.
`timescale 1ns/1ps
interface cmos_shift_reg_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
);
  logic             load;
  logic             shift_en;
  logic             dir;
  logic             ser_in;
  logic [WIDTH-1:0] d_in;
  logic [WIDTH-1:0] q;
  logic             ser_out;
  logic [CNT_W-1:0] fill;
  logic             full;

  modport master (
    output load, shift_en, dir, ser_in, d_in,
    input  q, ser_out, fill, full
  );

  modport slave (
    input  load, shift_en, dir, ser_in, d_in,
    output q, ser_out, fill, full
  );
endinterface

// File: rtl/cmos_shift_reg.sv
// WIDTH-bit shift/load register with saturating fill counter, built from pmos/nmos switches.
// Define CMOS_SR_DELAY_EN to give every switch a 1 ns delay; the default build is zero-delay.
`timescale 1ns/1ps
`ifdef CMOS_SR_DELAY_EN
  `define CSR_DLY #1
`else
  `define CSR_DLY
`endif

module cmos_shift_reg #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input logic             clk,
  input logic             rst_n,
  cmos_shift_reg_if.slave bus
);
  localparam int N = WIDTH + CNT_W;
  localparam logic [CNT_W-1:0] FULL_CODE = CNT_W'(WIDTH);

  supply1 vdd;
  supply0 gnd;

  wire             load     = bus.load;
  wire             shift_en = bus.shift_en;
  wire             dir      = bus.dir;
  wire             ser_in   = bus.ser_in;
  wire [WIDTH-1:0] d_in     = bus.d_in;

  wire rst, clk_b, load_b, shift_en_b, dir_b;
  pmos `CSR_DLY (rst, vdd, rst_n);
  nmos `CSR_DLY (rst, gnd, rst_n);
  pmos `CSR_DLY (clk_b, vdd, clk);
  nmos `CSR_DLY (clk_b, gnd, clk);
  pmos `CSR_DLY (load_b, vdd, load);
  nmos `CSR_DLY (load_b, gnd, load);
  pmos `CSR_DLY (shift_en_b, vdd, shift_en);
  nmos `CSR_DLY (shift_en_b, gnd, shift_en);
  pmos `CSR_DLY (dir_b, vdd, dir);
  nmos `CSR_DLY (dir_b, gnd, dir);

  // Latch enables are gated with rst_n so reset cuts off every transmission gate onto the storage nodes.
  wire m_open, m_open_b, s_open, s_open_b;
  nmos `CSR_DLY (m_open, clk_b, rst_n);
  pmos `CSR_DLY (m_open, clk_b, rst);
  nmos `CSR_DLY (m_open, gnd, rst);
  pmos `CSR_DLY (m_open_b, vdd, m_open);
  nmos `CSR_DLY (m_open_b, gnd, m_open);
  nmos `CSR_DLY (s_open, clk, rst_n);
  pmos `CSR_DLY (s_open, clk, rst);
  nmos `CSR_DLY (s_open, gnd, rst);
  pmos `CSR_DLY (s_open_b, vdd, s_open);
  nmos `CSR_DLY (s_open_b, gnd, s_open);

  wire [N-1:0]     nxt;
  wire [N-1:0]     state;
  wire [CNT_W-1:0] cnt_b;

  // Static master-slave cell: each node is either driven through its input gate or its feedback gate.
  for (genvar i = 0; i < N; i++) begin : g_flop
    wire m, m_b, m_fb, s, s_b, s_fb;
    nmos `CSR_DLY (m, nxt[i], m_open);
    pmos `CSR_DLY (m, nxt[i], m_open_b);
    nmos `CSR_DLY (m, m_fb, s_open);
    pmos `CSR_DLY (m, m_fb, s_open_b);
    nmos `CSR_DLY (m, gnd, rst);
    pmos `CSR_DLY (m_b, vdd, m);
    nmos `CSR_DLY (m_b, gnd, m);
    pmos `CSR_DLY (m_fb, vdd, m_b);
    nmos `CSR_DLY (m_fb, gnd, m_b);
    nmos `CSR_DLY (s, m_fb, s_open);
    pmos `CSR_DLY (s, m_fb, s_open_b);
    nmos `CSR_DLY (s, s_fb, m_open);
    pmos `CSR_DLY (s, s_fb, m_open_b);
    nmos `CSR_DLY (s, gnd, rst);
    pmos `CSR_DLY (s_b, vdd, s);
    nmos `CSR_DLY (s_b, gnd, s);
    pmos `CSR_DLY (s_fb, vdd, s_b);
    nmos `CSR_DLY (s_fb, gnd, s_b);
    assign state[i] = s;
    if (i >= WIDTH) begin : g_cnt_b
      assign cnt_b[i-WIDTH] = s_b;
    end
  end

  wire [WIDTH-1:0] from_lo = {state[WIDTH-2:0], ser_in};
  wire [WIDTH-1:0] from_hi = {ser_in, state[WIDTH-1:1]};

  for (genvar i = 0; i < WIDTH; i++) begin : g_next_q
    wire sh, hs, nx;
    nmos `CSR_DLY (sh, from_hi[i], dir);
    pmos `CSR_DLY (sh, from_hi[i], dir_b);
    nmos `CSR_DLY (sh, from_lo[i], dir_b);
    pmos `CSR_DLY (sh, from_lo[i], dir);
    nmos `CSR_DLY (hs, sh, shift_en);
    pmos `CSR_DLY (hs, sh, shift_en_b);
    nmos `CSR_DLY (hs, state[i], shift_en_b);
    pmos `CSR_DLY (hs, state[i], shift_en);
    nmos `CSR_DLY (nx, d_in[i], load);
    pmos `CSR_DLY (nx, d_in[i], load_b);
    nmos `CSR_DLY (nx, hs, load_b);
    pmos `CSR_DLY (nx, hs, load);
    assign nxt[i] = nx;
  end

  wire [CNT_W-1:0] cnt = state[N-1:WIDTH];
  wire [CNT_W-1:0] carry, carry_b;
  wire [CNT_W:0]   chain;
  wire [CNT_W-1:0] match, match_b;
  wire             full_n, full_b, c0, c0_b;

  // Increment is enabled only below WIDTH, which is what makes the counter saturate.
  nmos `CSR_DLY (c0, full_b, shift_en);
  pmos `CSR_DLY (c0, full_b, shift_en_b);
  nmos `CSR_DLY (c0, gnd, shift_en_b);
  pmos `CSR_DLY (c0_b, vdd, c0);
  nmos `CSR_DLY (c0_b, gnd, c0);
  assign carry[0]   = c0;
  assign carry_b[0] = c0_b;

  for (genvar i = 0; i < CNT_W; i++) begin : g_next_cnt
    wire sum, nx;
    nmos `CSR_DLY (sum, cnt_b[i], carry[i]);
    pmos `CSR_DLY (sum, cnt_b[i], carry_b[i]);
    nmos `CSR_DLY (sum, cnt[i], carry_b[i]);
    pmos `CSR_DLY (sum, cnt[i], carry[i]);
    nmos `CSR_DLY (nx, sum, load_b);
    pmos `CSR_DLY (nx, sum, load);
    nmos `CSR_DLY (nx, gnd, load);
    assign nxt[WIDTH+i] = nx;
    if (i < CNT_W - 1) begin : g_carry
      wire nd, c;
      nmos `CSR_DLY (nd, carry_b[i], cnt[i]);
      pmos `CSR_DLY (nd, carry_b[i], cnt_b[i]);
      pmos `CSR_DLY (nd, vdd, cnt[i]);
      pmos `CSR_DLY (c, vdd, nd);
      nmos `CSR_DLY (c, gnd, nd);
      assign carry[i+1]   = c;
      assign carry_b[i+1] = nd;
    end
  end

  // full is a pass-gate AND chain over per-bit matches against the constant WIDTH.
  assign chain[0] = 1'b1;
  for (genvar i = 0; i < CNT_W; i++) begin : g_full
    wire a;
    if (FULL_CODE[i]) begin : g_one
      assign match[i]   = cnt[i];
      assign match_b[i] = cnt_b[i];
    end else begin : g_zero
      assign match[i]   = cnt_b[i];
      assign match_b[i] = cnt[i];
    end
    nmos `CSR_DLY (a, chain[i], match[i]);
    pmos `CSR_DLY (a, chain[i], match_b[i]);
    nmos `CSR_DLY (a, gnd, match_b[i]);
    assign chain[i+1] = a;
  end
  assign full_n = chain[CNT_W];
  pmos `CSR_DLY (full_b, vdd, full_n);
  nmos `CSR_DLY (full_b, gnd, full_n);

  wire ser_out_n;
  nmos `CSR_DLY (ser_out_n, state[0], dir);
  pmos `CSR_DLY (ser_out_n, state[0], dir_b);
  nmos `CSR_DLY (ser_out_n, state[WIDTH-1], dir_b);
  pmos `CSR_DLY (ser_out_n, state[WIDTH-1], dir);

  assign bus.q       = state[WIDTH-1:0];
  assign bus.fill    = cnt;
  assign bus.full    = full_n;
  assign bus.ser_out = ser_out_n;
endmodule

`undef CSR_DLY

// File: tb/tb_cmos_shift_reg.sv
// Directed self-checking bench for cmos_shift_reg with hand-computed expected values.
// Samples 1 ns after edges, or 5 ns when CMOS_SR_DELAY_EN is defined.
`timescale 1ns/1ps
module tb_cmos_shift_reg;
  localparam int WIDTH = 8;
  localparam int CNT_W = $clog2(WIDTH + 1);
`ifdef CMOS_SR_DELAY_EN
  localparam int SAMPLE_DLY = 5;
  localparam int RST_DLY    = 3;
`else
  localparam int SAMPLE_DLY = 1;
  localparam int RST_DLY    = 1;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   check_count = 0;
  int   err_count   = 0;

  cmos_shift_reg_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) sr_bus ();

  cmos_shift_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sr_bus)
  );

  always #10 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual !== expected) begin
      err_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Drive one set of controls, let one rising edge capture them, then sample.
  task automatic applyStimulus(input logic ld, input logic sh, input logic dr, input logic si,
                               input logic [WIDTH-1:0] din);
    sr_bus.load     = ld;
    sr_bus.shift_en = sh;
    sr_bus.dir      = dr;
    sr_bus.ser_in   = si;
    sr_bus.d_in     = din;
    @(posedge clk);
    #(SAMPLE_DLY);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n           = 1'b0;
    sr_bus.load     = 1'b0;
    sr_bus.shift_en = 1'b0;
    sr_bus.dir      = 1'b0;
    sr_bus.ser_in   = 1'b0;
    sr_bus.d_in     = '0;

    // Reset with toggling inputs must keep everything cleared.
    repeat (3) begin
      sr_bus.d_in     = WIDTH'($urandom);
      sr_bus.ser_in   = 1'($urandom_range(0, 1));
      sr_bus.load     = 1'($urandom_range(0, 1));
      sr_bus.shift_en = 1'($urandom_range(0, 1));
      @(posedge clk);
      #(SAMPLE_DLY);
      checkOutput("rst_q", 32'(sr_bus.q), 'h0);
    end
    checkOutput("rst_fill", 32'(sr_bus.fill), 0);
    checkOutput("rst_full", 32'(sr_bus.full), 0);
    checkOutput("rst_ser_out", 32'(sr_bus.ser_out), 0);

    sr_bus.load     = 1'b0;
    sr_bus.shift_en = 1'b0;
    sr_bus.ser_in   = 1'b1;
    sr_bus.d_in     = 8'hFF;
    rst_n = 1'b1;
    #1;
    checkOutput("release_no_edge_q", 32'(sr_bus.q), 'h0);

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'hA5);
    checkOutput("load_q", 32'(sr_bus.q), 'hA5);
    checkOutput("load_fill", 32'(sr_bus.fill), 0);
    checkOutput("load_ser_out", 32'(sr_bus.ser_out), 1);

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
    checkOutput("shl3_q", 32'(sr_bus.q), 'h05);
    checkOutput("shl3_fill", 32'(sr_bus.fill), 3);
    checkOutput("shl3_full", 32'(sr_bus.full), 0);
    repeat (5) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    checkOutput("shl8_q", 32'(sr_bus.q), 'hA0);
    checkOutput("shl8_fill", 32'(sr_bus.fill), 8);
    checkOutput("shl8_full", 32'(sr_bus.full), 1);
    checkOutput("shl8_ser_out_msb", 32'(sr_bus.ser_out), 1);
    sr_bus.dir = 1'b1;
    #1;
    checkOutput("dir_flip_ser_out_lsb", 32'(sr_bus.ser_out), 0);
    checkOutput("dir_flip_q_hold", 32'(sr_bus.q), 'hA0);

    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'h81);
    checkOutput("load81_full_clear", 32'(sr_bus.full), 0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
    checkOutput("shr1_q", 32'(sr_bus.q), 'h40);
    checkOutput("shr1_ser_out", 32'(sr_bus.ser_out), 0);
    checkOutput("shr1_fill", 32'(sr_bus.fill), 1);
    repeat (7) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
    checkOutput("shr8_fill", 32'(sr_bus.fill), 8);
    repeat (3) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
    checkOutput("shr11_q", 32'(sr_bus.q), 'h00);
    checkOutput("shr11_fill_sat", 32'(sr_bus.fill), 8);
    checkOutput("shr11_full", 32'(sr_bus.full), 1);

    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 8'h3C);
    checkOutput("prio_q", 32'(sr_bus.q), 'h3C);
    checkOutput("prio_fill", 32'(sr_bus.fill), 0);
    checkOutput("prio_full", 32'(sr_bus.full), 0);
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 8'hFF);
    checkOutput("hold_q", 32'(sr_bus.q), 'h3C);
    checkOutput("hold_fill", 32'(sr_bus.fill), 0);

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 8'hFF);
    repeat (5) applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
    checkOutput("pre_rst_q", 32'(sr_bus.q), 'hFF);
    checkOutput("pre_rst_fill", 32'(sr_bus.fill), 5);
    // clk is high here, so this reset lands mid-cycle with the slave transparent.
    rst_n = 1'b0;
    #(RST_DLY);
    checkOutput("mid_rst_q", 32'(sr_bus.q), 'h00);
    checkOutput("mid_rst_fill", 32'(sr_bus.fill), 0);
    @(posedge clk);
    #(SAMPLE_DLY);
    checkOutput("mid_rst_hold_q", 32'(sr_bus.q), 'h00);
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
    checkOutput("post_rst_q", 32'(sr_bus.q), 'h01);
    checkOutput("post_rst_fill", 32'(sr_bus.fill), 1);

    $display("Result: errors=%0d of %0d checks", err_count, check_count);
    $finish;
  end
endmodule
